// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store data-memory stage behind the CPU datapath.
// Accepts a byte address and store data, performs byte/halfword/word accesses
// against an internal word-organised RAM, and inserts WAIT_CYC wait states
// per accepted access.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset
//   req_i    - access request, sampled only while idle
//   we_i     - 1 = store, 0 = load
//   size_i   - 00 byte, 01 halfword, 10 word, 11 illegal
//   sign_i   - loads: 1 = sign-extend, 0 = zero-extend
//   addr_i   - byte address
//   wdata_i  - store data (low-order bits for byte/halfword)
//   rdata_o  - formatted load data, held between loads
//   done_o   - one-cycle pulse on completion or rejection
//   err_o    - one-cycle pulse with done_o on a rejected request
//   busy_o   - high while an accepted access is in flight
module data_mem_ctrl #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned AW = ADDR_W + 2;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e         r_state, w_state_d;
  logic [3:0]     r_cnt, w_cnt_d;
  logic           r_we, w_we_d;
  logic [1:0]     r_size, w_size_d;
  logic           r_sign, w_sign_d;
  logic [AW-1:0]  r_addr, w_addr_d;
  logic [31:0]    r_wdata, w_wdata_d;
  logic [31:0]    r_rdata, w_rdata_d;
  logic           r_done, w_done_d;
  logic           r_err, w_err_d;
  logic           r_busy, w_busy_d;

  logic [31:0]    r_mem [DEPTH];

  logic             w_illegal;
  logic             w_exec;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic [31:0]      w_shift;
  logic [31:0]      w_load;
  logic [3:0]       w_be;
  logic [31:0]      w_wlane;

  // Address bits above the RAM index are deliberately dropped (aliasing).
  logic w_unused;
  assign w_unused = ^addr_i[31:AW];

  assign w_illegal = (size_i == 2'b11)
                   | ((size_i == 2'b01) & addr_i[0])
                   | ((size_i == 2'b10) & (|addr_i[1:0]));

  assign w_exec = (r_state == StBusy) && (r_cnt == 4'd0);
  assign w_idx  = r_addr[AW-1:2];
  assign w_word = r_mem[w_idx];

  // Right-justify the addressed lane(s), then extend.
  assign w_shift = w_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    unique case (r_size)
      2'b00:   w_load = {{24{r_sign & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = {{16{r_sign & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // Replicate store data across lanes; byte enables pick the addressed ones.
  always_comb begin
    w_be    = 4'b1111;
    w_wlane = r_wdata;
    unique case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
      end
    endcase
  end

  // RAM is not reset; a reset mid-access leaves r_state idle so no write fires.
  always_ff @(posedge clk_i) begin
    if (w_exec && r_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_we_d    = r_we;
    w_size_d  = r_size;
    w_sign_d  = r_sign;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_rdata_d = r_rdata;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    w_busy_d  = r_busy;
    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          if (w_illegal) begin
            w_done_d = 1'b1;
            w_err_d  = 1'b1;
          end else begin
            w_we_d    = we_i;
            w_size_d  = size_i;
            w_sign_d  = sign_i;
            w_addr_d  = addr_i[AW-1:0];
            w_wdata_d = wdata_i;
            w_cnt_d   = 4'(WAIT_CYC);
            w_busy_d  = 1'b1;
            w_state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (r_cnt != 4'd0) begin
          w_cnt_d = r_cnt - 4'd1;
        end else begin
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
          if (!r_we) w_rdata_d = w_load;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_we    <= w_we_d;
      r_size  <= w_size_d;
      r_sign  <= w_sign_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_rdata <= w_rdata_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_busy  <= w_busy_d;
    end
  end

  assign rdata_o = r_rdata;
  assign done_o  = r_done;
  assign err_o   = r_err;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int WAIT = 2;
  localparam int NBYTES = 512;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, we_i, sign_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        done_o, err_o, busy_o;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: byte-addressed memory plus the last loaded value.
  logic [7:0]  m [NBYTES];
  logic [31:0] exp_rdata;

  data_mem_ctrl #(.DEPTH(128), .ADDR_W(7), .WAIT_CYC(WAIT)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sign_i(sign_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic bit legal(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 0;
    if (size == 2'b01 && addr % 2 != 0) return 0;
    if (size == 2'b10 && addr % 4 != 0) return 0;
    return 1;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr);
    int n = nbytes(size);
    int b = int'(addr % NBYTES);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(m[b + i]) << (8 * i));
    if (sign && n == 1 && v >= 32'h80) v = v | 32'hFFFFFF00;
    if (sign && n == 2 && v >= 32'h8000) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int n = nbytes(size);
    int b = int'(addr % NBYTES);
    for (int i = 0; i < n; i++) m[b + i] = 8'((wdata >> (8 * i)) & 32'hFF);
  endtask

  // Entered and left #1 after a rising edge. Presents the request at once, so
  // chained calls keep req_i high across the done cycle (no idle gap).
  task automatic access(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int cyc;
    req_i = 1'b1; we_i = we; size_i = size; sign_i = sign; addr_i = addr; wdata_i = wdata;
    @(posedge clk); #1;
    if (!legal(size, addr)) begin
      check("rej_done", 32'(done_o), 32'd1);
      check("rej_err", 32'(err_o), 32'd1);
      check("rej_busy", 32'(busy_o), 32'd0);
      check("rej_rdata", rdata_o, exp_rdata);
    end else begin
      check("acc_busy", 32'(busy_o), 32'd1);
      check("acc_done", 32'(done_o), 32'd0);
      cyc = 0;
      while (!done_o && cyc < 20) begin
        if (cyc > 0) check("wait_busy", 32'(busy_o), 32'd1);
        // Garbage while busy must be ignored.
        req_i = 1'($urandom); we_i = 1'($urandom); size_i = 2'($urandom);
        sign_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
        @(posedge clk); #1;
        cyc++;
      end
      check("latency", 32'(cyc), 32'(WAIT + 1));
      check("end_busy", 32'(busy_o), 32'd0);
      check("end_err", 32'(err_o), 32'd0);
      if (we) model_store(size, addr, wdata);
      else exp_rdata = model_load(size, sign, addr);
      check(we ? "st_rdata" : "ld_rdata", rdata_o, exp_rdata);
    end
    req_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle_done", 32'(done_o), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    req_i = 0; we_i = 0; size_i = 0; sign_i = 0; addr_i = 0; wdata_i = 0;
    exp_rdata = 0;
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b1;
    idle_cycle();

    // Give every word a known value.
    for (int w = 0; w < 128; w++) access(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);

    // Directed word/byte/sign cases.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("t1_word", rdata_o, 32'hDEADBEEF);
    access(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("t2_word", rdata_o, 32'hDE55BEEF);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("t2_sbyte", rdata_o, 32'hFFFFFFDE);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("t2_ubyte", rdata_o, 32'h000000DE);

    // Rejections leave rdata and RAM alone.
    access(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    access(1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF);
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
    idle_cycle();
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("t3_word", rdata_o, 32'hDE55BEEF);

    // Aliasing modulo DEPTH words.
    access(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
    access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
    check("t4_wrap", rdata_o, 32'h12345678);

    // Back-to-back alternating store/load with req_i held high.
    for (int i = 0; i < 6; i++) begin
      a = 32'h80 + 32'(i * 4);
      access(1'b1, 2'b10, 1'b0, a, $urandom);
      access(1'b0, 2'b10, 1'b0, a, 32'h0);
    end

    // Reset one cycle into a store aborts it.
    access(1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; sign_i = 1'b0;
    addr_i = 32'h40; wdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_i = 1'b0;
    check("t6_acc_busy", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_rdata = 0;
    #1;
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_done", 32'(done_o), 32'd0);
    check("t6_rdata", rdata_o, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_done_hold", 32'(done_o), 32'd0);
    rst_i = 1'b1;
    idle_cycle();
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("t6_load", rdata_o, 32'h11111111);

    // Randomized mix, occasionally with idle gaps.
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom);
      a  = $urandom_range(0, 32'h7FF);
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      access(1'($urandom), sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
